// File: rtl/pattgen_seq_ctrl.sv
// rtl/pattgen_seq_ctrl.sv - descriptor FIFO plus playback FSM for one pattgen channel
// Pops queued descriptors into the channel config, enables it, waits for done and an optional gap.
module pattgen_seq_ctrl #(
  parameter int unsigned Depth = 4,
  parameter int unsigned GapW  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       desc_valid_i,
  output logic                       desc_ready_o,
  input  logic [63:0]                desc_data_i,
  input  logic [5:0]                 desc_len_i,
  input  logic [9:0]                 desc_reps_i,
  input  logic [31:0]                desc_prediv_i,
  input  logic [GapW-1:0]            gap_i,
  input  logic                       enable_i,
  input  logic                       abort_i,
  output logic [63:0]                ch_data_o,
  output logic [5:0]                 ch_len_o,
  output logic [9:0]                 ch_reps_o,
  output logic [31:0]                ch_prediv_o,
  output logic                       ch_enable_o,
  input  logic                       ch_done_i,
  output logic                       busy_o,
  output logic                       drained_o,
  output logic [$clog2(Depth):0]     level_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned DW = 64 + 6 + 10 + 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [63:0]       data_q, data_d;
  logic [5:0]        len_q, len_d;
  logic [9:0]        reps_q, reps_d;
  logic [31:0]       prediv_q, prediv_d;
  logic              drained_q, drained_d;
  logic [DW-1:0]     mem_q [Depth];

  logic [AW:0]       level;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              advance;
  logic [DW-1:0]     head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level        = wr_ptr_q - rd_ptr_q;
  assign full         = (level == (AW+1)'(Depth));
  assign empty        = (level == '0);
  assign desc_ready_o = !full && !abort_i;
  assign push         = desc_valid_i && desc_ready_o;
  assign head         = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    drained_d = 1'b0;
    pop       = 1'b0;
    advance   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i && !empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (ch_done_i) begin
          if (gap_i != '0) begin
            gap_cnt_d = gap_i;
            state_d   = GAP;
          end else begin
            advance = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GapW'(1)) begin
          advance = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // End of a pattern (directly or after its gap): chain the next one or go idle.
    if (advance) begin
      if (enable_i && !empty) begin
        pop     = 1'b1;
        state_d = LOAD;
      end else begin
        state_d   = IDLE;
        drained_d = empty;
      end
    end

    if (abort_i) begin
      state_d   = IDLE;
      pop       = 1'b0;
      drained_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    if (abort_i) begin
      rd_ptr_d = wr_ptr_q;
    end
  end

  always_comb begin
    data_d   = data_q;
    len_d    = len_q;
    reps_d   = reps_q;
    prediv_d = prediv_q;
    if (pop) begin
      {data_d, len_d, reps_d, prediv_d} = head;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {desc_data_i, desc_len_i, desc_reps_i, desc_prediv_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      gap_cnt_q <= '0;
      data_q    <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      prediv_q  <= '0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      len_q     <= len_d;
      reps_q    <= reps_d;
      prediv_q  <= prediv_d;
      drained_q <= drained_d;
    end
  end

  assign ch_data_o   = data_q;
  assign ch_len_o    = len_q;
  assign ch_reps_o   = reps_q;
  assign ch_prediv_o = prediv_q;
  assign ch_enable_o = (state_q == RUN);
  assign busy_o      = (state_q != IDLE);
  assign drained_o   = drained_q;
  assign level_o     = level;

endmodule
